ped_req_ctl: RTL and testbench
==============================

# ped_req_ctl

Pedestrian crossing request front end for the traffic-light controller. Synchronises and debounces the raw push button, latches a crossing request, and holds it until the traffic FSM acknowledges it. While the request is pending, it counts down a two-digit BCD maximum-wait value for the seven-segment display. After service it enforces a lockout before accepting new requests.

## Interface
- DEB_CYCLES, 16'd50000: consecutive cycles of a changed synced input required before the debounced level updates.
- MAX_WAIT, 8'h29: BCD value loaded into `wait_bcd` when a request is accepted.
- LOCKOUT_S, 4'd5: number of `sec_tick` pulses in the post-service lockout.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- sec_tick  in  1  one-cycle pulse, once per second.
- ped_btn  in  1  raw push button, asynchronous, active-high.
- req_ack  in  1  one-cycle pulse from the traffic FSM when the walk phase is granted.
- ped_req  out  1  level; high while a request is pending.
- wait_bcd  out  8  BCD remaining wait, tens in [7:4] and units in [3:0].
- req_led  out  1  pending indicator; blinks at the tick rate.
- urgent  out  1  high when the wait has expired and the request is still pending (feature-gated).

## Operation
- Input path:
  - Two-flop synchroniser on `ped_btn`, then the debounce counter.
  - The counter clears whenever the synced value equals the debounced level.
  - When the synced value differs for DEB_CYCLES consecutive cycles, the debounced level takes the synced value and the counter clears.
  - `press` is the one-cycle rising edge of the debounced level.
- FSM states: IDLE, PENDING, LOCKOUT.
- IDLE:
  - On `press`: go to PENDING, set `ped_req`=1, load `wait_bcd`=MAX_WAIT, set `req_led`=1.
  - `req_ack` is ignored.
- PENDING:
  - Each `sec_tick` decrements `wait_bcd` as two-digit BCD: units 0 borrows (tens-1, units 9). At 8'h00 the value saturates.
  - Each `sec_tick` also toggles `req_led`.
  - `press` is ignored.
  - On `req_ack`: go to LOCKOUT, clear `ped_req`, `req_led` and `wait_bcd` (8'h00), load the lockout count with LOCKOUT_S.
- LOCKOUT:
  - Each `sec_tick` decrements the lockout count.
  - A tick that finds the count at 1 (or 0) returns the FSM to IDLE.
  - `press` and `req_ack` are ignored.
- Arithmetic:
  - MAX_WAIT must be valid BCD.
  - If both digits of MAX_WAIT are 0, a press still enters PENDING, with `wait_bcd`=00 immediately.

## Timing
- Reset, at the first clk edge with `reset`=0:
  - State IDLE.
  - All outputs 0; `wait_bcd`=8'h00.
  - Synchroniser, debounced level and both counters at 0.
- Reset mid-operation drops any pending request without an acknowledge.
- Latency from a `ped_btn` change to the `ped_req` rise: 2 synchroniser cycles + DEB_CYCLES + 1 registered cycle.
- `req_ack` and `sec_tick` in the same cycle while PENDING: the ack wins and no decrement occurs.
- `press` and `req_ack` in the same cycle while IDLE: the press is accepted.
- `urgent` is registered and rises in the cycle after `wait_bcd` reaches 00 while PENDING. It clears with `ped_req`.
- All outputs are registered. No combinational path from input to output.

## Configuration
- PED_URGENT_EN defined:
  - `urgent` is driven as described.
  - Once `urgent` is set, `req_led` holds at 1 instead of blinking.
- PED_URGENT_EN undefined:
  - `urgent` is tied to 0.
  - `req_led` blinks for the whole PENDING period.
  - `wait_bcd` still saturates at 00.

## Structure
- Shared package `ped_pkg`:
  - State encoding constants: IDLE=2'd0, PENDING=2'd1, LOCKOUT=2'd2.
  - BCD limit constants: digit 9, value 8'h00.
- One sub-module, `bcd_cnt_dn2`: two-digit BCD down counter with synchronous load, enable and saturation at 00. It drives `wait_bcd`.
- Debounce logic and the FSM stay in the top level.

## Test plan
All scenarios use DEB_CYCLES=4, MAX_WAIT=8'h12, LOCKOUT_S=2.
- Debounce rejection: hold `ped_btn` high for 3 cycles, then low -> `ped_req` stays 0.
- Accept: hold `ped_btn` high for 10 cycles -> `ped_req`=1 exactly 7 cycles after the edge, `wait_bcd`=8'h12, `req_led`=1.
- Countdown: 3 ticks -> `wait_bcd` steps 12, 11, 10, 09 and `req_led` toggles each tick. 9 further ticks -> 00. 2 more ticks -> stays 00 and `urgent`=1 (macro on) or 0 (macro off).
- Ack collision: `req_ack` and `sec_tick` in the same cycle at `wait_bcd`=05 -> `ped_req`=0, `wait_bcd`=00, state LOCKOUT. A press during lockout is ignored. After 2 ticks the state is IDLE, and a new press is accepted.
- Reset: drive `reset`=0 for one edge while PENDING -> all outputs 0 on the next edge, state IDLE.

Source files
------------

// File: rtl/ped_pkg.sv
// ped_pkg: shared definitions for the pedestrian request front end.
//   - ped_state_e : controller state encoding
//   - BCD limits and a two-digit BCD decrement helper that saturates at 00
package ped_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        LOCKOUT = 2'd2
    } ped_state_e;

    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;
    localparam logic [7:0] BCD_ZERO      = 8'h00;

    // Two-digit BCD minus one; a zero units digit borrows from the tens.
    function automatic logic [7:0] bcd_dec2(input logic [7:0] v);
        logic [7:0] r;
        if (v == BCD_ZERO) begin
            r = BCD_ZERO;
        end else if (v[3:0] == 4'd0) begin
            r = {v[7:4] - 4'd1, BCD_DIGIT_MAX};
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_cnt_dn2.sv
// bcd_cnt_dn2: two-digit BCD down counter, saturating at 00.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-low reset (count -> 00)
//   load     in   load load_val this cycle (has priority over en)
//   load_val in 8 BCD value to load
//   en       in   decrement by one this cycle
//   cnt      out 8 current BCD count, tens in [7:4], units in [3:0]
module bcd_cnt_dn2
    import ped_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic [7:0] cnt
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            cnt_d = bcd_dec2(cnt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= BCD_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ped_req_ctl.sv
// ped_req_ctl: pedestrian crossing request front end.
// Synchronises and debounces the push button, latches a request until the
// traffic FSM acknowledges it, counts down a BCD maximum-wait display value
// while pending, then enforces a lockout of LOCKOUT_S seconds.
// Optional feature macro: PED_URGENT_EN (drives `urgent`, holds req_led on
// once urgent). Without it `urgent` is tied low.
// Ports:
//   clk       in     system clock
//   reset     in     synchronous active-low reset
//   sec_tick  in     one-cycle pulse per second
//   ped_btn   in     raw asynchronous push button, active high
//   req_ack   in     one-cycle walk-granted pulse from the traffic FSM
//   ped_req   out    request pending level
//   wait_bcd  out 8  remaining wait, BCD tens [7:4] units [3:0]
//   req_led   out    pending indicator, blinks per tick
//   urgent    out    wait expired with request still pending
//
// state   | meaning
// IDLE    | no request, waiting for a debounced press
// PENDING | request latched, counting down wait_bcd, waiting for req_ack
// LOCKOUT | request served, ignoring presses for LOCKOUT_S ticks
module ped_req_ctl
    import ped_pkg::*;
#(
    parameter logic [15:0] DEB_CYCLES = 16'd50000,
    parameter logic [7:0]  MAX_WAIT   = 8'h29,
    parameter logic [3:0]  LOCKOUT_S  = 4'd5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       ped_btn,
    input  logic       req_ack,
    output logic       ped_req,
    output logic [7:0] wait_bcd,
    output logic       req_led,
    output logic       urgent
);

    logic        sync1_q, sync2_q;
    logic        deb_q, deb_d, deb_dly_q;
    logic [15:0] deb_cnt_q, deb_cnt_d;
    logic        press;

    ped_state_e  state_q, state_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic        ped_req_q, ped_req_d;
    logic        req_led_q, req_led_d;
    logic        bcd_load, bcd_en;
    logic [7:0]  bcd_load_val;
    logic [7:0]  wait_w;

    // Debounce: count consecutive cycles the synced input disagrees.
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        if (sync2_q == deb_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_CYCLES - 16'd1) begin
            deb_d     = sync2_q;
            deb_cnt_d = '0;
        end else begin
            deb_cnt_d = deb_cnt_q + 16'd1;
        end
    end

    assign press = deb_q & ~deb_dly_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= ped_btn;
            sync2_q   <= sync1_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an ack beats a same-cycle tick in PENDING.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press) state_d = PENDING;
            PENDING: if (req_ack) state_d = LOCKOUT;
            LOCKOUT: if (sec_tick && (lock_cnt_q <= 4'd1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef PED_URGENT_EN
    logic urgent_q, urgent_d;
`endif

    // Output / datapath control logic
    always_comb begin
        ped_req_d    = ped_req_q;
        req_led_d    = req_led_q;
        lock_cnt_d   = lock_cnt_q;
        bcd_load     = 1'b0;
        bcd_load_val = MAX_WAIT;
        bcd_en       = 1'b0;
`ifdef PED_URGENT_EN
        urgent_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (press) begin
                    ped_req_d    = 1'b1;
                    req_led_d    = 1'b1;
                    bcd_load     = 1'b1;
                    bcd_load_val = MAX_WAIT;
                end
            end
            PENDING: begin
                if (req_ack) begin
                    ped_req_d    = 1'b0;
                    req_led_d    = 1'b0;
                    bcd_load     = 1'b1;
                    bcd_load_val = BCD_ZERO;
                    lock_cnt_d   = LOCKOUT_S;
                end else begin
                    bcd_en = sec_tick;
`ifdef PED_URGENT_EN
                    // Looks at the registered count so urgent lags 00 by a cycle.
                    urgent_d = (wait_w == BCD_ZERO);
                    if (urgent_q) begin
                        req_led_d = 1'b1;
                    end else if (sec_tick) begin
                        req_led_d = ~req_led_q;
                    end
`else
                    if (sec_tick) begin
                        req_led_d = ~req_led_q;
                    end
`endif
                end
            end
            LOCKOUT: begin
                if (sec_tick) begin
                    lock_cnt_d = (lock_cnt_q <= 4'd1) ? 4'd0 : lock_cnt_q - 4'd1;
                end
            end
            default: begin
                ped_req_d = 1'b0;
                req_led_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            lock_cnt_q <= '0;
            ped_req_q  <= 1'b0;
            req_led_q  <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            ped_req_q  <= ped_req_d;
            req_led_q  <= req_led_d;
        end
    end

`ifdef PED_URGENT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            urgent_q <= 1'b0;
        end else begin
            urgent_q <= urgent_d;
        end
    end
    assign urgent = urgent_q;
`else
    assign urgent = 1'b0;
`endif

    bcd_cnt_dn2 u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (bcd_load),
        .load_val (bcd_load_val),
        .en       (bcd_en),
        .cnt      (wait_w)
    );

    assign ped_req  = ped_req_q;
    assign req_led  = req_led_q;
    assign wait_bcd = wait_w;

endmodule

// File: tb/tb_ped_req_ctl.sv
// Bench for ped_req_ctl: directed scenarios plus randomized traffic checked
// against a seconds-based behavioural model.
module tb_ped_req_ctl;

    localparam logic [15:0] DEB  = 16'd4;
    localparam logic [7:0]  MAXW = 8'h12;
    localparam logic [3:0]  LOCK = 4'd2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sec_tick = 1'b0;
    logic       ped_btn = 1'b0;
    logic       req_ack = 1'b0;
    logic       ped_req;
    logic [7:0] wait_bcd;
    logic       req_led;
    logic       urgent;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ped_req_ctl #(
        .DEB_CYCLES (DEB),
        .MAX_WAIT   (MAXW),
        .LOCKOUT_S  (LOCK)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sec_tick (sec_tick),
        .ped_btn  (ped_btn),
        .req_ack  (req_ack),
        .ped_req  (ped_req),
        .wait_bcd (wait_bcd),
        .req_led  (req_led),
        .urgent   (urgent)
    );

`ifdef PED_URGENT_EN
    localparam bit URG_EN = 1'b1;
`else
    localparam bit URG_EN = 1'b0;
`endif

    // ---------------- behavioural model ----------------
    bit m_h0, m_h1;          // button samples one and two edges ago
    bit m_deb, m_deb_prev;
    int m_run;               // consecutive cycles synced level disagreed
    bit m_pend, m_lock_on;
    int m_lock_left;
    int m_wait;              // remaining wait in whole seconds
    bit m_req, m_led, m_urg;

    function automatic int bcd_to_int(input logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [7:0] int_to_bcd(input int n);
        logic [3:0] t, u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    function automatic logic [1:0] m_state();
        if (m_pend) return 2'd1;
        if (m_lock_on) return 2'd2;
        return 2'd0;
    endfunction

    task automatic model_step();
        bit p;
        bit s;
`ifdef PED_URGENT_EN
        bit urg_old;
`endif
        if (!reset) begin
            m_h0 = 0; m_h1 = 0; m_deb = 0; m_deb_prev = 0; m_run = 0;
            m_pend = 0; m_lock_on = 0; m_lock_left = 0; m_wait = 0;
            m_req = 0; m_led = 0; m_urg = 0;
        end else begin
            p = m_deb && !m_deb_prev;
            if (m_pend) begin
                if (req_ack) begin
                    m_pend = 0; m_req = 0; m_led = 0; m_wait = 0; m_urg = 0;
                    m_lock_on = 1; m_lock_left = int'(LOCK);
                end else begin
`ifdef PED_URGENT_EN
                    urg_old = m_urg;
                    m_urg = (m_wait == 0);
                    if (urg_old) m_led = 1;
                    else if (sec_tick) m_led = !m_led;
`else
                    if (sec_tick) m_led = !m_led;
`endif
                    if (sec_tick && m_wait > 0) m_wait = m_wait - 1;
                end
            end else if (m_lock_on) begin
                if (sec_tick) begin
                    if (m_lock_left <= 1) begin
                        m_lock_on = 0;
                        m_lock_left = 0;
                    end else begin
                        m_lock_left = m_lock_left - 1;
                    end
                end
            end else if (p) begin
                m_pend = 1; m_req = 1; m_led = 1; m_urg = 0;
                m_wait = bcd_to_int(MAXW);
            end
            m_deb_prev = m_deb;
            s = m_h1;
            if (s == m_deb) begin
                m_run = 0;
            end else if (m_run + 1 >= int'(DEB)) begin
                m_deb = s;
                m_run = 0;
            end else begin
                m_run = m_run + 1;
            end
            m_h1 = m_h0;
            m_h0 = ped_btn;
        end
    endtask

    // One clock: model advances at the edge, caller observes at the falling edge.
    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic hold_btn(input bit v, input int n);
        ped_btn = v;
        repeat (n) step();
    endtask

    task automatic pulse_tick();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks += 5;
        if (ped_req !== 1'b0) begin errors++; $display("FAIL reset_ped_req: got %b want 0", ped_req); end
        if (wait_bcd !== 8'h00) begin errors++; $display("FAIL reset_wait: got %h want 00", wait_bcd); end
        if (req_led !== 1'b0) begin errors++; $display("FAIL reset_led: got %b want 0", req_led); end
        if (urgent !== 1'b0) begin errors++; $display("FAIL reset_urgent: got %b want 0", urgent); end
        if (2'(dut.state_q) !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dut.state_q); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_debounce_reject();
        bit seen = 1'b0;
        ped_btn = 1'b1;
        repeat (3) begin step(); seen |= ped_req; end
        ped_btn = 1'b0;
        repeat (10) begin step(); seen |= ped_req; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL debounce_reject: ped_req seen %b want 0", seen); end
    endtask

    task automatic test_accept();
        ped_btn = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 6) begin
                checks++;
                if (ped_req !== 1'b0) begin errors++; $display("FAIL accept_early: got %b want 0 at cycle 6", ped_req); end
            end
            if (i == 7) begin
                checks += 3;
                if (ped_req !== 1'b1) begin errors++; $display("FAIL accept_req: got %b want 1 at cycle 7", ped_req); end
                if (wait_bcd !== 8'h12) begin errors++; $display("FAIL accept_wait: got %h want 12", wait_bcd); end
                if (req_led !== 1'b1) begin errors++; $display("FAIL accept_led: got %b want 1", req_led); end
            end
        end
        hold_btn(1'b0, 10);
    endtask

    task automatic test_countdown();
        logic [7:0] exp_seq [4] = '{8'h12, 8'h11, 8'h10, 8'h09};
        bit exp_led = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            pulse_tick();
            exp_led = !exp_led;
            checks += 2;
            if (wait_bcd !== exp_seq[k]) begin errors++; $display("FAIL countdown_wait%0d: got %h want %h", k, wait_bcd, exp_seq[k]); end
            if (req_led !== exp_led) begin errors++; $display("FAIL countdown_led%0d: got %b want %b", k, req_led, exp_led); end
            step();
        end
        repeat (9) begin pulse_tick(); step(); end
        checks += 2;
        if (wait_bcd !== 8'h00) begin errors++; $display("FAIL countdown_zero: got %h want 00", wait_bcd); end
        if (urgent !== 1'b0 && !URG_EN) begin errors++; $display("FAIL urgent_off: got %b want 0", urgent); end
        repeat (2) begin pulse_tick(); step(); end
        checks += 4;
        if (wait_bcd !== 8'h00) begin errors++; $display("FAIL countdown_sat: got %h want 00", wait_bcd); end
        if (urgent !== URG_EN) begin errors++; $display("FAIL countdown_urgent: got %b want %b", urgent, URG_EN); end
        if (req_led !== 1'b1) begin errors++; $display("FAIL countdown_led_end: got %b want 1", req_led); end
        if (ped_req !== 1'b1) begin errors++; $display("FAIL countdown_req: got %b want 1", ped_req); end
    endtask

    task automatic test_ack_collision();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        hold_btn(1'b1, 10);
        hold_btn(1'b0, 10);
        repeat (7) begin pulse_tick(); step(); end
        checks++;
        if (wait_bcd !== 8'h05) begin errors++; $display("FAIL ack_pre_wait: got %h want 05", wait_bcd); end
        req_ack = 1'b1;
        sec_tick = 1'b1;
        step();
        req_ack = 1'b0;
        sec_tick = 1'b0;
        checks += 5;
        if (ped_req !== 1'b0) begin errors++; $display("FAIL ack_req: got %b want 0", ped_req); end
        if (wait_bcd !== 8'h00) begin errors++; $display("FAIL ack_wait: got %h want 00", wait_bcd); end
        if (req_led !== 1'b0) begin errors++; $display("FAIL ack_led: got %b want 0", req_led); end
        if (urgent !== 1'b0) begin errors++; $display("FAIL ack_urgent: got %b want 0", urgent); end
        if (2'(dut.state_q) !== 2'd2) begin errors++; $display("FAIL ack_state: got %0d want 2", dut.state_q); end
        hold_btn(1'b1, 10);
        hold_btn(1'b0, 10);
        checks += 2;
        if (ped_req !== 1'b0) begin errors++; $display("FAIL lockout_press: got %b want 0", ped_req); end
        if (2'(dut.state_q) !== 2'd2) begin errors++; $display("FAIL lockout_hold: got %0d want 2", dut.state_q); end
        pulse_tick();
        step();
        checks++;
        if (2'(dut.state_q) !== 2'd2) begin errors++; $display("FAIL lockout_tick1: got %0d want 2", dut.state_q); end
        pulse_tick();
        step();
        checks++;
        if (2'(dut.state_q) !== 2'd0) begin errors++; $display("FAIL lockout_exit: got %0d want 0", dut.state_q); end
        hold_btn(1'b1, 10);
        checks += 2;
        if (ped_req !== 1'b1) begin errors++; $display("FAIL repress_req: got %b want 1", ped_req); end
        if (wait_bcd !== 8'h12) begin errors++; $display("FAIL repress_wait: got %h want 12", wait_bcd); end
        hold_btn(1'b0, 10);
    endtask

    task automatic test_reset_mid();
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks += 5;
        if (ped_req !== 1'b0) begin errors++; $display("FAIL midrst_req: got %b want 0", ped_req); end
        if (wait_bcd !== 8'h00) begin errors++; $display("FAIL midrst_wait: got %h want 00", wait_bcd); end
        if (req_led !== 1'b0) begin errors++; $display("FAIL midrst_led: got %b want 0", req_led); end
        if (urgent !== 1'b0) begin errors++; $display("FAIL midrst_urgent: got %b want 0", urgent); end
        if (2'(dut.state_q) !== 2'd0) begin errors++; $display("FAIL midrst_state: got %0d want 0", dut.state_q); end
        step();
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 5000; c++) begin
            if (hold == 0) begin
                ped_btn = 1'($urandom_range(0, 1));
                hold = int'($urandom_range(1, 12));
            end
            hold--;
            sec_tick = ($urandom_range(0, 7) == 0);
            req_ack  = ($urandom_range(0, 149) == 0);
            reset    = ($urandom_range(0, 799) != 0);
            step();
            checks += 5;
            if (ped_req !== m_req) begin errors++; $display("FAIL rand_req c%0d: got %b want %b", c, ped_req, m_req); end
            if (wait_bcd !== int_to_bcd(m_wait)) begin errors++; $display("FAIL rand_wait c%0d: got %h want %h", c, wait_bcd, int_to_bcd(m_wait)); end
            if (req_led !== m_led) begin errors++; $display("FAIL rand_led c%0d: got %b want %b", c, req_led, m_led); end
            if (urgent !== m_urg) begin errors++; $display("FAIL rand_urgent c%0d: got %b want %b", c, urgent, m_urg); end
            if (2'(dut.state_q) !== m_state()) begin errors++; $display("FAIL rand_state c%0d: got %0d want %0d", c, dut.state_q, m_state()); end
        end
        sec_tick = 1'b0;
        req_ack  = 1'b0;
        reset    = 1'b1;
    endtask

    initial begin
        test_reset();
        test_debounce_reject();
        test_accept();
        test_countdown();
        test_ack_collision();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
